vga_scan_ctrl: RTL



---
 rtl/vga_scan_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: pixel-rate divider, x/y scan counters, and a single-port
// framebuffer arbiter where the display read slot always beats the drawing writer.
module vga_scan_ctrl #(
  parameter int CLK_DIV   = 2,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int SHIFT     = 2,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic              pix_en,
  output logic              line_end,
  output logic              frame_end,
  output logic [DATA_W-1:0] pixel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FB_W  = H_VISIBLE >> SHIFT;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       X_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]       Y_VIS    = 10'(V_VISIBLE);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [DATA_W-1:0] r_pixel;
  logic              r_rd_slot;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_vld;

  logic              w_pix_en;
  logic              w_line_end;
  logic              w_frame_end;
  logic              w_visible;
  logic              w_rd_slot;
  logic              w_grant;
  logic [31:0]       w_disp_full;

  assign w_pix_en    = (r_div_cnt == DIV_LAST);
  assign w_line_end  = w_pix_en && (r_x == X_LAST);
  assign w_frame_end = w_line_end && (r_y == Y_LAST);
  assign w_visible   = (r_x < X_VIS) && (r_y < Y_VIS);
  assign w_rd_slot   = (r_div_cnt == '0) && w_visible;
  assign w_disp_full = 32'(r_y >> SHIFT) * 32'(FB_W) + 32'(r_x >> SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      if (w_pix_en) r_div_cnt <= '0;
      else          r_div_cnt <= r_div_cnt + DIV_ONE;
      if (w_pix_en) begin
        if (w_line_end) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  // Read data returns the clock after the slot; for CLK_DIV>2 it is parked in
  // r_hold so later write slots cannot disturb what reaches the pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_slot  <= 1'b0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_pixel    <= '0;
    end else begin
      r_rd_slot <= w_rd_slot;
      if (r_rd_slot) r_hold <= mem_rdata;
      if (w_pix_en) begin
        r_hold_vld <= 1'b0;
        if (r_rd_slot)       r_pixel <= mem_rdata;
        else if (r_hold_vld) r_pixel <= r_hold;
        else                 r_pixel <= '0;
      end else if (r_rd_slot) begin
        r_hold_vld <= 1'b1;
      end
    end
  end

  // Writer handshake: wr_req/wr_addr/wr_data are held until a clock in which
  // wr_ack=1; that clock performs the write and the writer may then move on.
  assign w_grant = rst_n && wr_req && !w_rd_slot;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      mem_addr  = w_grant ? wr_addr : w_disp_full[ADDR_W-1:0];
      mem_wdata = wr_data;
    end
  end

  assign mem_we    = w_grant;
  assign wr_ack    = w_grant;
  assign x         = r_x;
  assign y         = r_y;
  assign pix_en    = w_pix_en;
  assign line_end  = w_line_end;
  assign frame_end = w_frame_end;
  assign pixel     = r_pixel;

endmodule
